// File: rtl/ddr_bank_cmd_sequencer.sv
// DDR bank command sequencer: expands packed user commands into PRECHARGE/ACTIVE/READ/WRITE/REFRESH
// scheduler commands, tracking the open row of every bank and enforcing tRCD, tRP and tRFC gaps.
module ddr_bank_cmd_sequencer #(
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 10,
    parameter int BANK_BITS = 3,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RFC     = 32,
    localparam int CMD_W    = ROW_BITS + COL_BITS + BANK_BITS + 3,
    localparam int NB       = 2 ** BANK_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CMD_W-1:0]     cmd_in,
    input  logic                 ref_req,
    output logic                 ref_ack,
    output logic                 sch_valid,
    input  logic                 sch_ready,
    output logic [3:0]           sch_cmd,
    output logic [BANK_BITS-1:0] sch_bank,
    output logic [ROW_BITS-1:0]  sch_row,
    output logic [COL_BITS-1:0]  sch_col,
    output logic                 sch_bl,
    output logic                 sch_ap
);

    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_READ      = 4'd1;
    localparam logic [3:0] CMD_WRITE     = 4'd2;
    localparam logic [3:0] CMD_REFRESH   = 4'd5;
    localparam logic [3:0] CMD_ACTIVE    = 4'd6;
    localparam logic [3:0] CMD_PRECHARGE = 4'd7;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_PRE         = 4'd1;
    localparam logic [3:0] S_WAIT_RP     = 4'd2;
    localparam logic [3:0] S_ACT         = 4'd3;
    localparam logic [3:0] S_WAIT_RCD    = 4'd4;
    localparam logic [3:0] S_RW          = 4'd5;
    localparam logic [3:0] S_REF_PRE     = 4'd6;
    localparam logic [3:0] S_REF_WAIT_RP = 4'd7;
    localparam logic [3:0] S_REF         = 4'd8;
    localparam logic [3:0] S_WAIT_RFC    = 4'd9;

    localparam int MAX_RP_RCD = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int MAX_T      = (MAX_RP_RCD > T_RFC) ? MAX_RP_RCD : T_RFC;
    localparam int CNT_W      = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [NB-1:0]        open_flags;
    logic [ROW_BITS-1:0]  open_row [NB];

    logic                 lat_rw;
    logic [ROW_BITS-1:0]  lat_row;
    logic                 lat_bl;
    logic                 lat_ap;
    logic [COL_BITS-1:0]  lat_col;
    logic [BANK_BITS-1:0] lat_bank;

    logic                 in_rw;
    logic [ROW_BITS-1:0]  in_row;
    logic                 in_bl;
    logic                 in_ap;
    logic [COL_BITS-1:0]  in_col;
    logic [BANK_BITS-1:0] in_bank;

    logic [BANK_BITS-1:0] ref_bank;
    logic [NB-1:0]        remaining_open;
    logic                 any_open;

    assign in_rw   = cmd_in[CMD_W-1];
    assign in_row  = cmd_in[CMD_W-2 -: ROW_BITS];
    assign in_bl   = cmd_in[COL_BITS + BANK_BITS + 1];
    assign in_ap   = cmd_in[COL_BITS + BANK_BITS];
    assign in_col  = cmd_in[BANK_BITS +: COL_BITS];
    assign in_bank = cmd_in[BANK_BITS-1:0];

    assign cmd_ready = (state == S_IDLE) && !ref_req;
    assign any_open  = |open_flags;

    // Refresh closes banks lowest index first; the flags only change on a handshake, so this stays stable.
    always_comb begin
        ref_bank = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (open_flags[i]) begin
                ref_bank = BANK_BITS'(i);
            end
        end
        remaining_open = open_flags & ~(NB'(1) << ref_bank);
    end

    always_comb begin
        sch_valid = 1'b0;
        sch_cmd   = CMD_NOP;
        sch_bank  = '0;
        sch_row   = '0;
        sch_col   = '0;
        sch_bl    = 1'b0;
        sch_ap    = 1'b0;
        ref_ack   = 1'b0;
        case (state)
            S_PRE: begin
                sch_valid = 1'b1;
                sch_cmd   = CMD_PRECHARGE;
                sch_bank  = lat_bank;
            end
            S_ACT: begin
                sch_valid = 1'b1;
                sch_cmd   = CMD_ACTIVE;
                sch_bank  = lat_bank;
                sch_row   = lat_row;
            end
            S_RW: begin
                sch_valid = 1'b1;
                sch_cmd   = lat_rw ? CMD_READ : CMD_WRITE;
                sch_bank  = lat_bank;
                sch_col   = lat_col;
                sch_bl    = lat_bl;
                sch_ap    = lat_ap;
            end
            S_REF_PRE: begin
                sch_valid = 1'b1;
                sch_cmd   = CMD_PRECHARGE;
                sch_bank  = ref_bank;
            end
            S_REF: begin
                sch_valid = 1'b1;
                sch_cmd   = CMD_REFRESH;
                ref_ack   = sch_ready;
            end
            default: ;
        endcase
    end

    // Wait states exit when the counter reaches 1, so the next command is valid exactly T cycles after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            open_flags <= '0;
            for (int i = 0; i < NB; i++) begin
                open_row[i] <= '0;
            end
            lat_rw   <= 1'b0;
            lat_row  <= '0;
            lat_bl   <= 1'b0;
            lat_ap   <= 1'b0;
            lat_col  <= '0;
            lat_bank <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ref_req) begin
                        state <= any_open ? S_REF_PRE : S_REF;
                    end else if (cmd_valid) begin
                        lat_rw   <= in_rw;
                        lat_row  <= in_row;
                        lat_bl   <= in_bl;
                        lat_ap   <= in_ap;
                        lat_col  <= in_col;
                        lat_bank <= in_bank;
                        if (open_flags[in_bank] && (open_row[in_bank] == in_row)) begin
                            state <= S_RW;
                        end else if (open_flags[in_bank]) begin
                            state <= S_PRE;
                        end else begin
                            state <= S_ACT;
                        end
                    end
                end
                S_PRE: begin
                    if (sch_ready) begin
                        open_flags[lat_bank] <= 1'b0;
                        if (T_RP > 1) begin
                            cnt   <= RP_LOAD;
                            state <= S_WAIT_RP;
                        end else begin
                            state <= S_ACT;
                        end
                    end
                end
                S_WAIT_RP: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_ACT;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_ACT: begin
                    if (sch_ready) begin
                        open_flags[lat_bank] <= 1'b1;
                        open_row[lat_bank]   <= lat_row;
                        if (T_RCD > 1) begin
                            cnt   <= RCD_LOAD;
                            state <= S_WAIT_RCD;
                        end else begin
                            state <= S_RW;
                        end
                    end
                end
                S_WAIT_RCD: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_RW;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_RW: begin
                    if (sch_ready) begin
                        if (lat_ap) begin
                            open_flags[lat_bank] <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                end
                S_REF_PRE: begin
                    if (sch_ready) begin
                        open_flags[ref_bank] <= 1'b0;
                        if (remaining_open == '0) begin
                            if (T_RP > 1) begin
                                cnt   <= RP_LOAD;
                                state <= S_REF_WAIT_RP;
                            end else begin
                                state <= S_REF;
                            end
                        end
                    end
                end
                S_REF_WAIT_RP: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_REF;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_REF: begin
                    if (sch_ready) begin
                        if (T_RFC > 1) begin
                            cnt   <= RFC_LOAD;
                            state <= S_WAIT_RFC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_RFC: begin
                    if (cnt <= CNT_ONE) begin
                        state <= S_IDLE;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_bank_cmd_sequencer.sv
// Directed bench for ddr_bank_cmd_sequencer: row hit/miss/conflict, auto-precharge, refresh and reset.
module tb_ddr_bank_cmd_sequencer;

    localparam int ROW_BITS  = 13;
    localparam int COL_BITS  = 10;
    localparam int BANK_BITS = 3;
    localparam int CMD_W     = ROW_BITS + COL_BITS + BANK_BITS + 3;

    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_RD  = 4'd1;
    localparam logic [3:0] C_WR  = 4'd2;
    localparam logic [3:0] C_REF = 4'd5;
    localparam logic [3:0] C_ACT = 4'd6;
    localparam logic [3:0] C_PRE = 4'd7;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [CMD_W-1:0]     cmd_in = '0;
    logic                 ref_req = 1'b0;
    logic                 ref_ack;
    logic                 sch_valid;
    logic                 sch_ready = 1'b0;
    logic [3:0]           sch_cmd;
    logic [BANK_BITS-1:0] sch_bank;
    logic [ROW_BITS-1:0]  sch_row;
    logic [COL_BITS-1:0]  sch_col;
    logic                 sch_bl;
    logic                 sch_ap;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ddr_bank_cmd_sequencer #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BANK_BITS(BANK_BITS),
        .T_RCD(4), .T_RP(4), .T_RFC(32)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_in(cmd_in),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .sch_valid(sch_valid), .sch_ready(sch_ready), .sch_cmd(sch_cmd),
        .sch_bank(sch_bank), .sch_row(sch_row), .sch_col(sch_col),
        .sch_bl(sch_bl), .sch_ap(sch_ap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] packCmd(input logic rw, input logic [ROW_BITS-1:0] row,
                                                 input logic bl, input logic ap,
                                                 input logic [COL_BITS-1:0] col,
                                                 input logic [BANK_BITS-1:0] bank);
        return {rw, row, bl, ap, col, bank};
    endfunction

    // Offer a command and hold it until accepted; returns the acceptance cycle.
    task automatic applyStimulus(input string tag, input logic [CMD_W-1:0] c, output int acc);
        bit got = 0;
        acc = -1;
        cmd_in    = c;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (cmd_ready) begin
                acc = cyc;
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) checkOutput({tag, "_accept_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the next issued command, check it, and take the handshake.
    task automatic expectIssue(input string tag, input logic [3:0] ec, input logic [BANK_BITS-1:0] eb,
                               input logic [ROW_BITS-1:0] er, input logic [COL_BITS-1:0] ecol,
                               input logic ebl, input logic eap, output int hs);
        bit found = 0;
        hs = -1;
        sch_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (sch_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_cmd"}, 64'(sch_cmd), 64'(ec));
            checkOutput({tag, "_bank"}, 64'(sch_bank), 64'(eb));
            if (ec == C_ACT) checkOutput({tag, "_row"}, 64'(sch_row), 64'(er));
            if (ec == C_RD || ec == C_WR) begin
                checkOutput({tag, "_col_bl_ap"}, 64'({sch_col, sch_bl, sch_ap}), 64'({ecol, ebl, eap}));
            end
            checkOutput({tag, "_ref_ack"}, 64'(ref_ack), 64'(ec == C_REF));
            hs = cyc;
            @(negedge clk);
        end
    endtask

    initial begin
        int acc, hs_a, hs_b, hs_c;
        bit got;

        // Reset state
        #2;
        checkOutput("reset_sch", 64'({sch_valid, sch_cmd, ref_ack}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_ready", 64'(cmd_ready), 64'd1);
        checkOutput("reset_idle_out", 64'({sch_valid, sch_cmd, sch_bank, sch_row, sch_col, sch_bl, sch_ap}), 64'd0);

        // Reset in the middle of the tRCD wait
        applyStimulus("t1_cmd", packCmd(1'b0, 13'h0007, 1'b0, 1'b0, 10'h001, 3'd0), acc);
        expectIssue("t1_act", C_ACT, 3'd0, 13'h0007, '0, 1'b0, 1'b0, hs_a);
        rst = 1'b1;
        #1;
        checkOutput("t1_rst_sch", 64'({sch_valid, sch_cmd}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t1_rst_ready", 64'(cmd_ready), 64'd1);
        applyStimulus("t1_cmd2", packCmd(1'b0, 13'h0007, 1'b0, 1'b0, 10'h001, 3'd0), acc);
        expectIssue("t1_act2", C_ACT, 3'd0, 13'h0007, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t1_wr", C_WR, 3'd0, '0, 10'h001, 1'b0, 1'b0, hs_b);

        // Closed bank with backpressure on ACTIVE
        sch_ready = 1'b0;
        applyStimulus("t2_cmd", packCmd(1'b0, 13'h0123, 1'b1, 1'b0, 10'h010, 3'd2), acc);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("t2_stall", 64'({sch_valid, sch_cmd, sch_bank, sch_row}),
                        64'({1'b1, C_ACT, 3'd2, 13'h0123}));
            @(negedge clk);
        end
        expectIssue("t2_act", C_ACT, 3'd2, 13'h0123, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t2_wr", C_WR, 3'd2, '0, 10'h010, 1'b1, 1'b0, hs_b);
        checkOutput("t2_rcd_gap", 64'(hs_b - hs_a), 64'd4);

        // Row hit
        applyStimulus("t3_cmd", packCmd(1'b1, 13'h0123, 1'b0, 1'b0, 10'h020, 3'd2), acc);
        expectIssue("t3_rd", C_RD, 3'd2, '0, 10'h020, 1'b0, 1'b0, hs_a);
        #1;
        checkOutput("t3_ready_after", 64'(cmd_ready), 64'd1);

        // Row conflict
        applyStimulus("t4_cmd", packCmd(1'b1, 13'h0456, 1'b0, 1'b0, 10'h030, 3'd2), acc);
        expectIssue("t4_pre", C_PRE, 3'd2, '0, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t4_act", C_ACT, 3'd2, 13'h0456, '0, 1'b0, 1'b0, hs_b);
        checkOutput("t4_rp_gap", 64'(hs_b - hs_a >= 4), 64'd1);
        expectIssue("t4_rd", C_RD, 3'd2, '0, 10'h030, 1'b0, 1'b0, hs_c);
        checkOutput("t4_rcd_gap", 64'(hs_c - hs_b >= 4), 64'd1);

        // Auto-precharge closes the row
        applyStimulus("t5_cmd", packCmd(1'b0, 13'h0010, 1'b0, 1'b1, 10'h004, 3'd3), acc);
        expectIssue("t5_act", C_ACT, 3'd3, 13'h0010, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t5_wr", C_WR, 3'd3, '0, 10'h004, 1'b0, 1'b1, hs_b);
        applyStimulus("t5_cmd2", packCmd(1'b1, 13'h0010, 1'b0, 1'b0, 10'h008, 3'd3), acc);
        expectIssue("t5_act2", C_ACT, 3'd3, 13'h0010, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t5_rd", C_RD, 3'd3, '0, 10'h008, 1'b0, 1'b0, hs_b);

        // Refresh with banks 1 and 5 open and a same-cycle pending command
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("t6_open1", packCmd(1'b0, 13'h0020, 1'b0, 1'b0, 10'h000, 3'd1), acc);
        expectIssue("t6_act1", C_ACT, 3'd1, 13'h0020, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t6_wr1", C_WR, 3'd1, '0, 10'h000, 1'b0, 1'b0, hs_a);
        applyStimulus("t6_open5", packCmd(1'b1, 13'h0030, 1'b0, 1'b0, 10'h002, 3'd5), acc);
        expectIssue("t6_act5", C_ACT, 3'd5, 13'h0030, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t6_rd5", C_RD, 3'd5, '0, 10'h002, 1'b0, 1'b0, hs_a);
        ref_req   = 1'b1;
        cmd_in    = packCmd(1'b1, 13'h0020, 1'b0, 1'b0, 10'h005, 3'd1);
        cmd_valid = 1'b1;
        #1;
        checkOutput("t6_ready_tie", 64'(cmd_ready), 64'd0);
        expectIssue("t6_pre1", C_PRE, 3'd1, '0, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t6_pre5", C_PRE, 3'd5, '0, '0, 1'b0, 1'b0, hs_b);
        expectIssue("t6_ref", C_REF, 3'd0, '0, '0, 1'b0, 1'b0, hs_c);
        checkOutput("t6_rp_gap", 64'(hs_c - hs_b >= 4), 64'd1);
        #1;
        checkOutput("t6_ack_pulse", 64'(ref_ack), 64'd0);
        ref_req = 1'b0;
        got = 0;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (cmd_ready) begin
                acc = cyc;
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("t6_accept_seen", 64'(got), 64'd1);
        checkOutput("t6_rfc_gap", 64'(acc - hs_c), 64'd32);
        @(negedge clk);
        cmd_valid = 1'b0;
        expectIssue("t6_act_after", C_ACT, 3'd1, 13'h0020, '0, 1'b0, 1'b0, hs_a);
        expectIssue("t6_rd_after", C_RD, 3'd1, '0, 10'h005, 1'b0, 1'b0, hs_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_bank_cmd_sequencer.md
Name: ddr_bank_cmd_sequencer

Overview:
- Parametrised successor to the fixed-width DDR command word. It accepts one packed user command at a time, with configurable row, column and bank widths.
- It tracks the open row of every bank and expands each user command into the scheduler command stream: PRECHARGE, ACTIVE, READ/WRITE and REFRESH.
- It enforces T_RCD, T_RP and T_RFC gaps with internal counters.
- It sits between the host command FIFO and the DDR timing/PHY issue stage.

Parameters:
ROW_BITS, 13, row address width
COL_BITS, 10, column address width
BANK_BITS, 3, bank address width; NB = 2**BANK_BITS banks
T_RCD, 4, minimum cycles from ACTIVE handshake to READ/WRITE valid
T_RP, 4, minimum cycles from PRECHARGE handshake to next ACTIVE/REFRESH valid
T_RFC, 32, minimum cycles from REFRESH handshake to next command valid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_in  in  CMD_W  CMD_W=ROW_BITS+COL_BITS+BANK_BITS+3; MSB->LSB: r_w(1=read,0=write), row, burst_length(0=BL4,1=BL8), auto_precharge, col, bank
ref_req  in  1  refresh request level, held until ref_ack
ref_ack  out  1  one-cycle pulse on REFRESH handshake
sch_valid  out  1  scheduler command valid
sch_ready  in  1  downstream accepts sch command
sch_cmd  out  4  NOP=0, READ=1, WRITE=2, REFRESH=5, ACTIVE=6, PRECHARGE=7
sch_bank  out  BANK_BITS  target bank
sch_row  out  ROW_BITS  row (ACTIVE)
sch_col  out  COL_BITS  column (READ/WRITE)
sch_bl  out  1  burst length (READ/WRITE)
sch_ap  out  1  auto-precharge (READ/WRITE)

Behaviour:
- Reset (async, any time, including mid-sequence): state S_IDLE, all open flags 0, counters 0, latched command 0. sch_valid=0, sch_cmd=NOP, other sch_* 0, ref_ack=0, and cmd_ready=1 once rst deasserts with ref_req=0.
- cmd_ready = (state==S_IDLE) && !ref_req (combinational). Refresh therefore wins a same-cycle tie with cmd_valid.
- Per-bank table: open[b] (1 bit) and open_row[b] (ROW_BITS).
- States: S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_REF_PRE, S_REF_WAIT_RP, S_REF, S_WAIT_RFC.
- From S_IDLE, on an accepted command, latch it and go to:
  - S_RW on a row hit (open[bank] && open_row==row);
  - S_ACT if the bank is closed;
  - S_PRE if the bank is open on a different row (row conflict).
- From S_IDLE with ref_req=1: go to S_REF_PRE if any bank is open, else S_REF.
- Handshake rule: in every issuing state sch_valid=1, and sch_* stay stable until sch_ready. The transition happens on the handshake cycle. Non-issuing states drive sch_valid=0 and sch_cmd=NOP.
- S_PRE: issue PRECHARGE(bank); clear open[bank]; go to S_WAIT_RP.
- S_ACT: issue ACTIVE(bank,row); set open[bank]=1 and open_row[bank]=row; go to S_WAIT_RCD.
- S_WAIT_RP: wait T_RP-1 cycles, then S_ACT. S_ACT therefore asserts sch_valid no earlier than T_RP cycles after the PRECHARGE handshake.
- S_WAIT_RCD: same rule, so READ/WRITE is valid no earlier than T_RCD cycles after the ACTIVE handshake. If a parameter is <=1, its wait state is skipped.
- S_RW: issue READ or WRITE with col, bl and ap. On the handshake:
  - if ap=1, clear open[bank];
  - go to S_IDLE.
- Auto-precharge recovery timing is owned downstream.
- S_REF_PRE: issue PRECHARGE to the lowest-index open bank and clear its flag. Repeat until no bank is open, then go to S_REF_WAIT_RP (T_RP counted from the last PRECHARGE handshake), then S_REF.
- S_REF: issue REFRESH with sch_bank=0. ref_ack pulses in the handshake cycle. Go to S_WAIT_RFC, hold T_RFC-1 cycles, then return to S_IDLE.
- Counter width is $clog2(max(T_RCD,T_RP,T_RFC)+1). Counters load on the handshake and decrement to 0; there is no wrap.
- A ref_req arriving mid-command does not abort the command. It is serviced at the next S_IDLE, before any new command.
- sch_ready asserted while sch_valid=0 is ignored.

Test Plan:
1. Assert rst mid-S_WAIT_RCD -> immediately sch_valid=0, sch_cmd=0; after release, cmd_ready=1 and all banks closed (next command to the same row issues ACTIVE).
2. WRITE bank 2, row 0x0123, col 0x010, BL8, ap=0, with banks closed -> ACTIVE(b2,0x0123). With sch_ready held low 3 cycles, sch_* stay stable. Then WRITE(col 0x010, bl=1) becomes valid exactly 4 cycles after the ACTIVE handshake.
3. Then READ bank 2, row 0x0123, col 0x020 -> single READ, no ACTIVE; cmd_ready returns 1 the cycle after the handshake.
4. Then READ bank 2, row 0x0456 -> PRECHARGE(b2), ACTIVE(b2,0x0456) at >=4 cycles later, READ at >=4 cycles after that.
5. WRITE bank 3, row 0x0010, ap=1, then READ on the same row -> second command issues ACTIVE again (row was closed by auto-precharge).
6. Banks 1 and 5 open, ref_req and cmd_valid asserted in the same cycle -> cmd_ready=0. Sequence is PRECHARGE b1, PRECHARGE b5, REFRESH >=4 cycles after the last PRECHARGE, one-cycle ref_ack. The pending command is accepted exactly 32 cycles after the REFRESH handshake, with ACTIVE first.
